dm_cache: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate cache that sits between the CPU datapath and one memory port (instruction or data). One instance per port replaces the datapath's direct 64-bit fetch path. Line width, set count and word width are parameters; read hits complete in the request cycle; misses fill a whole line over a single-request memory handshake.

---
 rtl/dm_cache_pkg.sv | 18 +
 rtl/dm_cache_array.sv | 52 +++++
 rtl/dm_cache.sv | 148 ++++++++++++++
 tb/tb_dm_cache.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped cache.
package dm_cache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - offset_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage: combinational read, one line-write and one word-write port.
module dm_cache_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4,
  parameter int TAG_W      = 12,
  parameter int INDEX_W    = 2,
  parameter int OFFSET_W   = 2
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic [INDEX_W-1:0]                    rd_index,
  output logic                                  rd_valid,
  output logic [TAG_W-1:0]                      rd_tag,
  output logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  rd_line,
  input  logic                                  line_we,
  input  logic [INDEX_W-1:0]                    line_index,
  input  logic [TAG_W-1:0]                      line_tag,
  input  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  line_data,
  input  logic                                  word_we,
  input  logic [INDEX_W-1:0]                    word_index,
  input  logic [OFFSET_W-1:0]                   word_offset,
  input  logic [WORD_SIZE-1:0]                  word_data
);

  logic [SETS-1:0]                                valid_q;
  logic [SETS-1:0][TAG_W-1:0]                     tag_q;
  logic [SETS-1:0][LINE_WORDS-1:0][WORD_SIZE-1:0] data_q;

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge Clk) begin
    if (Reset)        valid_q <= '0;
    else if (line_we) valid_q[line_index] <= 1'b1;
  end

  // Tag/data are not reset; writes are suppressed while Reset is high so an
  // abandoned fill or write leaves the arrays untouched.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (line_we) begin
        tag_q[line_index]  <= line_tag;
        data_q[line_index] <= line_data;
      end else if (word_we) begin
        data_q[word_index][word_offset] <= word_data;
      end
    end
  end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache: FSM, hit logic, stats.
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_ready,
  output logic                            mem_readM,
  output logic                            mem_writeM,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
`endif
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, SETS);

  state_t state_q, state_d;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] rd_line, fill_line;
  logic                hit, line_we, word_we;
  logic [WORD_SIZE-1:0] rdata_q;

  assign offset    = cpu_addr[OFFSET_W-1:0];
  assign index     = cpu_addr[OFFSET_W +: INDEX_W];
  assign tag       = cpu_addr[ADDR_W-1 -: TAG_W];
  assign fill_line = mem_rdata;
  assign hit       = rd_valid && (rd_tag == tag);

  dm_cache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .SETS      (SETS),
    .TAG_W     (TAG_W),
    .INDEX_W   (INDEX_W),
    .OFFSET_W  (OFFSET_W)
  ) u_array (
    .Clk        (Clk),
    .Reset      (Reset),
    .rd_index   (index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .line_we    (line_we),
    .line_index (index),
    .line_tag   (tag),
    .line_data  (fill_line),
    .word_we    (word_we),
    .word_index (index),
    .word_offset(offset),
    .word_data  (cpu_wdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset)                             rdata_q <= '0;
    else if (state_q == FILL && mem_ready) rdata_q <= fill_line[offset];
  end

  always_comb begin
    state_d     = state_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    mem_readM   = 1'b0;
    mem_writeM  = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    unique case (state_q)
      IDLE: if (cpu_req) begin
        if (cpu_we) state_d = WRITE;
        else if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = rd_line[offset];
        end else state_d = FILL;
      end
      FILL: begin
        mem_readM   = 1'b1;
        mem_address = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          line_we = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = rdata_q;
        state_d   = IDLE;
      end
      WRITE: begin
        mem_writeM  = 1'b1;
        mem_address = cpu_addr;
        mem_wdata   = cpu_wdata;
        // Write-through: keep a resident line coherent, never allocate on miss.
        if (mem_ready) begin
          cpu_ready = 1'b1;
          word_we   = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic stat_hit;
  assign stat_hit = (state_q == IDLE) || (state_q == WRITE && hit);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cpu_ready) begin
      if (stat_hit) hit_count  <= hit_count + 16'd1;
      else          miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Directed self-checking bench for dm_cache (stats checks when CACHE_STATS_EN).
module tb_dm_cache;

  logic        Clk = 1'b0;
  logic        Reset, cpu_req, cpu_we, mem_ready;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_address, mem_wdata;
  logic        cpu_ready, mem_readM, mem_writeM;
  logic [63:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  dm_cache dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_readM  (mem_readM),
    .mem_writeM (mem_writeM),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Stimulus driver: starts at posedge+1, runs one CPU request with a memory
  // that answers after `lat` request cycles, and reports what it observed.
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int lat, input logic [63:0] line,
                        output logic [15:0] rdata, output int cycles,
                        output int n_rd, output int n_wr,
                        output logic [15:0] maddr, output logic [15:0] mwdata,
                        output logic both, output logic tmo);
    logic done;
    done = 1'b0; rdata = '0; cycles = -1; n_rd = 0; n_wr = 0;
    maddr = '0; mwdata = '0; both = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_rdata = line;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_readM && mem_writeM) both = 1'b1;
      if (mem_readM || mem_writeM) begin
        maddr = mem_address; mwdata = mem_wdata;
        if (mem_readM) n_rd++; else n_wr++;
        if ((mem_readM ? n_rd : n_wr) == lat) begin
          mem_ready = 1'b1;
          #1;
        end
      end
      if (cpu_ready) begin
        rdata = cpu_rdata; cycles = c; done = 1'b1;
      end
      @(posedge Clk); #1;
      mem_ready = 1'b0;
      if (done) break;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset;
    Reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ready = 0; mem_rdata = '0;
    repeat (2) @(posedge Clk);
    #1; Reset = 1'b0;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    n_checks++; if (mem_readM !== 1'b0) begin n_fail++; $display("FAIL reset_mem_readM got %b want 0", mem_readM); end
    n_checks++; if (mem_writeM !== 1'b0) begin n_fail++; $display("FAIL reset_mem_writeM got %b want 0", mem_writeM); end
    n_checks++; if (mem_address !== 16'h0) begin n_fail++; $display("FAIL reset_mem_address got %h want 0000", mem_address); end
    n_checks++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h want 0000", cpu_rdata); end
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
    @(posedge Clk); #1;
  endtask

  task automatic test_read_miss;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo;
    access(0, 16'h0010, 0, 2, 64'h4444_3333_2222_1111, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL miss_timeout got %b want 0", tmo); end
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL miss_latency got %0d want 3", cyc); end
    n_checks++; if (nr != 2) begin n_fail++; $display("FAIL miss_readM_cycles got %0d want 2", nr); end
    n_checks++; if (ma !== 16'h0010) begin n_fail++; $display("FAIL miss_mem_address got %h want 0010", ma); end
    n_checks++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL miss_rdata got %h want 1111", rd); end
  endtask

  task automatic test_read_hit;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo;
    access(0, 16'h0012, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 0) begin n_fail++; $display("FAIL hit_latency got %0d want 0", cyc); end
    n_checks++; if (nr != 0) begin n_fail++; $display("FAIL hit_readM got %0d want 0", nr); end
    n_checks++; if (rd !== 16'h3333) begin n_fail++; $display("FAIL hit_rdata got %h want 3333", rd); end
  endtask

  task automatic test_write_hit;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo;
    access(1, 16'h0011, 16'hBEEF, 3, 64'h0, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", cyc); end
    n_checks++; if (nw != 3 || nr != 0) begin n_fail++; $display("FAIL wr_writeM_cycles got %0d/%0d want 3/0", nw, nr); end
    n_checks++; if (ma !== 16'h0011) begin n_fail++; $display("FAIL wr_mem_address got %h want 0011", ma); end
    n_checks++; if (mw !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem_wdata got %h want beef", mw); end
    n_checks++; if (both !== 1'b0) begin n_fail++; $display("FAIL wr_both_req got %b want 0", both); end
    // back-to-back hits right after the write completes
    access(0, 16'h0011, 0, 1, 64'h0, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 0 || rd !== 16'hBEEF) begin n_fail++; $display("FAIL wr_hit_update got %h@%0d want beef@0", rd, cyc); end
    access(0, 16'h0013, 0, 1, 64'h0, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 0 || rd !== 16'h4444) begin n_fail++; $display("FAIL wr_neighbour got %h@%0d want 4444@0", rd, cyc); end
  endtask

  task automatic test_write_miss;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo;
    access(1, 16'h0040, 16'h1234, 1, 64'h0, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 1 || ma !== 16'h0040 || mw !== 16'h1234) begin n_fail++; $display("FAIL wmiss_write got cyc %0d addr %h data %h want 1 0040 1234", cyc, ma, mw); end
    access(0, 16'h0040, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (nr != 1 || ma !== 16'h0040) begin n_fail++; $display("FAIL wmiss_no_alloc got %0d fills at %h want 1 at 0040", nr, ma); end
    n_checks++; if (cyc != 2 || rd !== 16'hDDDD) begin n_fail++; $display("FAIL wmiss_read got %h@%0d want dddd@2", rd, cyc); end
  endtask

  task automatic test_conflict;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo; int fills;
`ifdef CACHE_STATS_EN
    logic [15:0] h0, m0;
    h0 = hit_count; m0 = miss_count;
`endif
    fills = 0;
    access(0, 16'h0010, 0, 1, 64'h1004_1003_1002_1001, rd, cyc, nr, nw, ma, mw, both, tmo);
    fills += nr;
    n_checks++; if (rd !== 16'h1001) begin n_fail++; $display("FAIL conf_a_rdata got %h want 1001", rd); end
    access(0, 16'h0050, 0, 2, 64'h5004_5003_5002_5001, rd, cyc, nr, nw, ma, mw, both, tmo);
    fills += (nr > 0) ? 1 : 0;
    n_checks++; if (rd !== 16'h5001 || ma !== 16'h0050) begin n_fail++; $display("FAIL conf_b got %h at %h want 5001 at 0050", rd, ma); end
    access(0, 16'h0010, 0, 1, 64'h9004_9003_9002_9001, rd, cyc, nr, nw, ma, mw, both, tmo);
    fills += nr;
    n_checks++; if (rd !== 16'h9001) begin n_fail++; $display("FAIL conf_refill got %h want 9001", rd); end
    n_checks++; if (fills != 3) begin n_fail++; $display("FAIL conf_fills got %0d want 3", fills); end
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_count - h0 !== 16'd0 || miss_count - m0 !== 16'd3) begin n_fail++; $display("FAIL conf_stats got %0d/%0d want 0/3", hit_count - h0, miss_count - m0); end
`endif
  endtask

  task automatic test_reset_during_fill;
    logic [15:0] rd, ma, mw; int cyc, nr, nw; logic both, tmo;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050; mem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
    @(posedge Clk); #2;
    n_checks++; if (mem_readM !== 1'b1) begin n_fail++; $display("FAIL rst_fill_entered got %b want 1", mem_readM); end
    Reset = 1'b1; mem_ready = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; mem_ready = 1'b0; cpu_req = 1'b0;
    #1;
    n_checks++; if ({cpu_ready, mem_readM, mem_writeM} !== 3'b000 || mem_address !== 16'h0) begin n_fail++; $display("FAIL rst_outputs got %b%b%b %h want 000 0000", cpu_ready, mem_readM, mem_writeM, mem_address); end
    @(posedge Clk); #1;
    access(0, 16'h0010, 0, 1, 64'h7774_7773_7772_7771, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (nr != 1 || cyc != 2 || rd !== 16'h7771) begin n_fail++; $display("FAIL rst_no_stale got %0d fills %h@%0d want 1 7771@2", nr, rd, cyc); end
    access(0, 16'h0050, 0, 1, 64'h6664_6663_6662_6661, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (nr != 1 || rd !== 16'h6661) begin n_fail++; $display("FAIL rst_abandoned_fill got %0d fills %h want 1 6661", nr, rd); end
    access(0, 16'h0051, 0, 1, 64'h0, rd, cyc, nr, nw, ma, mw, both, tmo);
    n_checks++; if (cyc != 0 || rd !== 16'h6662) begin n_fail++; $display("FAIL rst_b2b_hit got %h@%0d want 6662@0", rd, cyc); end
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_count !== 16'd1 || miss_count !== 16'd2) begin n_fail++; $display("FAIL rst_stats got %0d/%0d want 1/2", hit_count, miss_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_during_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
